// File: rtl/ntt_sched_pkg.sv
// Shared types and sizing helpers for the NTT frame scheduler.
package ntt_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } sched_state_t;

    localparam int INFLIGHT_W = 4;

    function automatic int beat_idx_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/ntt_start_delay_line.sv
// Stage-start delay line: replays the stage-0 start pulse every STAGE_GAP cycles
// down the stage vector, so overlapping frames produce independent pulses.
module ntt_start_delay_line #(
    parameter int NUM_STAGES = 9,
    parameter int STAGE_GAP  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    output logic [NUM_STAGES-1:0] stage_start
);

    localparam int LEN = (NUM_STAGES - 1) * STAGE_GAP;

    logic [LEN-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr <= '0;
        end else begin
            sr <= LEN'({sr, start_in});
        end
    end

    assign stage_start[0] = start_in;

    // Bit STAGE_GAP*k-1 holds the stage-0 pulse delayed by exactly k*STAGE_GAP cycles.
    for (genvar k = 1; k < NUM_STAGES; k++) begin : g_tap
        assign stage_start[k] = sr[k*STAGE_GAP-1];
    end

endmodule

// File: rtl/ntt_frame_scheduler.sv
// Frame admission, stage sequencing and output framing for the NTT core.
// Define NTT_SCHED_STATS_EN to add the frames_in/frames_out statistics counters.
module ntt_frame_scheduler
    import ntt_sched_pkg::*;
#(
    parameter int NUM_STAGES      = 9,
    parameter int BEATS_PER_FRAME = 8,
    parameter int STAGE_GAP       = 8,
    parameter int MAX_INFLIGHT    = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic                                   beat_en,
    output logic [beat_idx_w(BEATS_PER_FRAME)-1:0] beat_idx,
    output logic [NUM_STAGES-1:0]                  stage_start,
    input  logic [NUM_STAGES-1:0]                  core_out_start,
    output logic                                   out_valid,
    output logic                                   out_last,
    output logic [INFLIGHT_W-1:0]                  inflight,
    output logic                                   err_underrun,
    output logic                                   err_overrun
`ifdef NTT_SCHED_STATS_EN
    ,
    output logic [31:0]                            frames_in,
    output logic [31:0]                            frames_out
`endif
);

    localparam int BW = beat_idx_w(BEATS_PER_FRAME);
    localparam logic [BW-1:0]         LAST_BEAT   = BW'(BEATS_PER_FRAME - 1);
    localparam logic [INFLIGHT_W-1:0] MAX_CREDITS = INFLIGHT_W'(MAX_INFLIGHT);

    sched_state_t          state, state_next;
    logic [BW-1:0]         beat_idx_q, beat_idx_next;
    logic                  in_ready_q, in_ready_next;
    logic [INFLIGHT_W-1:0] inflight_q, inflight_next;
    logic                  admit, retire, out_rise, start_prev;
    logic                  out_active;
    logic [BW-1:0]         out_cnt;
    logic                  underrun_q, overrun_q;
    logic                  unused_stage_bits;

    assign unused_stage_bits = ^core_out_start[NUM_STAGES-2:0];

    assign in_ready     = in_ready_q;
    assign beat_en      = in_valid && in_ready_q;
    assign beat_idx     = beat_idx_q;
    assign inflight     = inflight_q;
    assign err_underrun = underrun_q;
    assign err_overrun  = overrun_q;
    assign admit        = beat_en && (state == IDLE);
    assign out_rise     = core_out_start[NUM_STAGES-1] && !start_prev;
    assign out_valid    = out_active;
    assign out_last     = out_active && (out_cnt == LAST_BEAT);
    assign retire       = out_last;

    ntt_start_delay_line #(
        .NUM_STAGES (NUM_STAGES),
        .STAGE_GAP  (STAGE_GAP)
    ) u_delay (
        .clk         (clk),
        .rst         (rst),
        .start_in    (admit),
        .stage_start (stage_start)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            beat_idx_q <= '0;
            in_ready_q <= 1'b0;
            inflight_q <= '0;
        end else begin
            state      <= state_next;
            beat_idx_q <= beat_idx_next;
            in_ready_q <= in_ready_next;
            inflight_q <= inflight_next;
        end
    end

    // The core cannot stall, so FILL advances the beat index whether or not a beat arrives.
    always_comb begin
        state_next    = state;
        beat_idx_next = beat_idx_q;
        inflight_next = inflight_q;
        case (state)
            IDLE: begin
                if (admit) begin
                    state_next    = FILL;
                    beat_idx_next = BW'(1);
                end
            end
            FILL: begin
                if (beat_idx_q == LAST_BEAT) begin
                    state_next    = IDLE;
                    beat_idx_next = '0;
                end else begin
                    beat_idx_next = beat_idx_q + BW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        if (admit && !retire) begin
            inflight_next = inflight_q + INFLIGHT_W'(1);
        end else if (!admit && retire) begin
            inflight_next = inflight_q - INFLIGHT_W'(1);
        end
        in_ready_next = (state_next == FILL) || (inflight_next < MAX_CREDITS);
    end

    // Output frames are only opened by a clean start while idle with something in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            start_prev <= 1'b0;
            out_active <= 1'b0;
            out_cnt    <= '0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            start_prev <= core_out_start[NUM_STAGES-1];
            underrun_q <= underrun_q || ((state == FILL) && !in_valid);
            overrun_q  <= overrun_q || (out_rise && (out_active || (inflight_q == '0)));
            if (out_rise && !out_active && (inflight_q != '0)) begin
                out_active <= 1'b1;
                out_cnt    <= '0;
            end else if (out_active) begin
                out_cnt <= out_cnt + BW'(1);
                if (out_last) begin
                    out_active <= 1'b0;
                end
            end
        end
    end

`ifdef NTT_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            frames_in  <= '0;
            frames_out <= '0;
        end else begin
            frames_in  <= frames_in + {31'd0, admit};
            frames_out <= frames_out + {31'd0, retire};
        end
    end
`endif

endmodule

// File: tb/tb_ntt_frame_scheduler.sv
// Directed, table-driven bench for ntt_frame_scheduler (default parameters).
module tb_ntt_frame_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [8:0] core_out_start = '0;
    logic       in_ready, beat_en;
    logic [2:0] beat_idx;
    logic [8:0] stage_start;
    logic       out_valid, out_last;
    logic [3:0] inflight;
    logic       err_underrun, err_overrun;
`ifdef NTT_SCHED_STATS_EN
    logic [31:0] frames_in, frames_out;
`endif

    int checks = 0;
    int fails  = 0;

    typedef struct {
        string       tag;
        logic        v;
        logic        os;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ntt_frame_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .beat_en        (beat_en),
        .beat_idx       (beat_idx),
        .stage_start    (stage_start),
        .core_out_start (core_out_start),
        .out_valid      (out_valid),
        .out_last       (out_last),
        .inflight       (inflight),
        .err_underrun   (err_underrun),
        .err_overrun    (err_overrun)
`ifdef NTT_SCHED_STATS_EN
        ,
        .frames_in      (frames_in),
        .frames_out     (frames_out)
`endif
    );

    function automatic logic [21:0] mk(input logic rdy, input logic en, input logic [2:0] idx,
                                       input logic [8:0] ss, input logic ov, input logic ol,
                                       input logic [3:0] inf, input logic ur, input logic orr);
        return {rdy, en, idx, ss, ov, ol, inf, ur, orr};
    endfunction

    function automatic logic [21:0] snap();
        return {in_ready, beat_en, beat_idx, stage_start, out_valid, out_last,
                inflight, err_underrun, err_overrun};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle's inputs just after the edge and returns at the following negedge.
    task automatic applyStimulus(input logic v, input logic os);
        @(posedge clk);
        #1;
        in_valid       = v;
        core_out_start = os ? 9'h100 : 9'h000;
        @(negedge clk);
    endtask

    task automatic addVec(input string tag, input logic v, input logic os, input logic [21:0] e);
        vec_t r;
        r.tag = tag;
        r.v   = v;
        r.os  = os;
        r.exp = e;
        vecs.push_back(r);
    endtask

    task automatic runTable();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].v, vecs[i].os);
            checkOutput(vecs[i].tag, {10'd0, snap()}, {10'd0, vecs[i].exp});
        end
        vecs.delete();
    endtask

    // Leaves the bench in cycle C0: reset just released, registers still at reset values.
    task automatic doReset();
        @(posedge clk);
        #1;
        rst            = 1'b0;
        in_valid       = 1'b0;
        core_out_start = '0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", {10'd0, snap()}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int starts[$];

        // Single frame: beats 0..7, stage pulses every 8 cycles from t0 = C1.
        doReset();
        addVec("f1_beat0", 1'b1, 1'b0, mk(1, 1, 3'd0, 9'h001, 0, 0, 4'd0, 0, 0));
        for (int i = 1; i < 8; i++)
            addVec($sformatf("f1_beat%0d", i), 1'b1, 1'b0, mk(1, 1, 3'(i), 9'h000, 0, 0, 4'd1, 0, 0));
        addVec("f1_after", 1'b0, 1'b0, mk(1, 0, 3'd0, 9'h002, 0, 0, 4'd1, 0, 0));
        runTable();
        for (int off = 9; off <= 66; off++) begin
            logic [8:0] exp_ss;
            exp_ss = '0;
            if (off % 8 == 0) exp_ss[off/8] = 1'b1;
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("f1_stage_t%0d", off), {23'd0, stage_start}, {23'd0, exp_ss});
        end

        // Credit limit: continuous input, no output starts.
        doReset();
        for (int i = 1; i <= 60; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (stage_start[0]) starts.push_back(i);
        end
        checkOutput("credit_admits", starts.size(), 4);
        foreach (starts[k])
            checkOutput($sformatf("credit_start%0d_cycle", k), starts[k], 1 + 8 * k);
        checkOutput("credit_ready_low", {31'd0, in_ready}, 0);
        checkOutput("credit_inflight", {28'd0, inflight}, 4);
        applyStimulus(1'b1, 1'b1);
        checkOutput("ostart_no_valid_yet", {31'd0, out_valid}, 0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("oframe%0d_valid_last_ready", i),
                        {29'd0, out_valid, out_last, in_ready}, {29'd0, 1'b1, (i == 8), 1'b0});
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput("credit_return",
                    {25'd0, in_ready, beat_en, stage_start[0], inflight},
                    {25'd0, 1'b1, 1'b1, 1'b1, 4'd3});
        applyStimulus(1'b1, 1'b0);
        checkOutput("credit_reuse_inflight", {28'd0, inflight}, 4);

        // Underrun on beat 3: frame keeps its schedule, flag sticks.
        doReset();
        addVec("ur_beat0", 1'b1, 1'b0, mk(1, 1, 3'd0, 9'h001, 0, 0, 4'd0, 0, 0));
        addVec("ur_beat1", 1'b1, 1'b0, mk(1, 1, 3'd1, 9'h000, 0, 0, 4'd1, 0, 0));
        addVec("ur_beat2", 1'b1, 1'b0, mk(1, 1, 3'd2, 9'h000, 0, 0, 4'd1, 0, 0));
        addVec("ur_beat3", 1'b0, 1'b0, mk(1, 0, 3'd3, 9'h000, 0, 0, 4'd1, 0, 0));
        addVec("ur_beat4", 1'b1, 1'b0, mk(1, 1, 3'd4, 9'h000, 0, 0, 4'd1, 1, 0));
        addVec("ur_beat5", 1'b1, 1'b0, mk(1, 1, 3'd5, 9'h000, 0, 0, 4'd1, 1, 0));
        addVec("ur_beat6", 1'b1, 1'b0, mk(1, 1, 3'd6, 9'h000, 0, 0, 4'd1, 1, 0));
        addVec("ur_beat7", 1'b1, 1'b0, mk(1, 1, 3'd7, 9'h000, 0, 0, 4'd1, 1, 0));
        addVec("ur_after", 1'b0, 1'b0, mk(1, 0, 3'd0, 9'h002, 0, 0, 4'd1, 1, 0));
        runTable();

        // Spurious output start with nothing in flight.
        doReset();
        addVec("ov_pulse", 1'b0, 1'b1, mk(1, 0, 3'd0, 9'h000, 0, 0, 4'd0, 0, 0));
        addVec("ov_flag",  1'b0, 1'b0, mk(1, 0, 3'd0, 9'h000, 0, 0, 4'd0, 0, 1));
        addVec("ov_stick", 1'b0, 1'b0, mk(1, 0, 3'd0, 9'h000, 0, 0, 4'd0, 0, 1));
        runTable();

        // Reset at t0+20 discards pending stage pulses.
        doReset();
        for (int i = 1; i <= 20; i++) applyStimulus(i <= 8, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_outputs", {10'd0, snap()}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("midreset_no_pulse%0d", i), {23'd0, stage_start}, 32'd0);
        end
        checkOutput("midreset_inflight", {28'd0, inflight}, 0);

        // Three frames in, two out.
        doReset();
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("stats_inflight", {28'd0, inflight}, 1);
        checkOutput("stats_errors", {30'd0, err_underrun, err_overrun}, 0);
`ifdef NTT_SCHED_STATS_EN
        checkOutput("stats_frames_in", frames_in, 3);
        checkOutput("stats_frames_out", frames_out, 2);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/ntt_frame_scheduler.md
# ntt_frame_scheduler

Frame-level controller for the NTT pipeline core. It admits input frames from an upstream beat stream under a valid/ready handshake and counts the beats of each frame. It generates the per-stage `in_start` pulse vector that sequences the core's stages, and tracks the core's `out_start` to frame the output stream and return in-flight credits. It sits between the host/stream fabric and the NTT core, beside the beat-serialising front end.

## Interface
- `NUM_STAGES`, 9: width of the stage-start vectors.
- `BEATS_PER_FRAME`, 8: beats per polynomial frame (N / lanes); power of two, ≥ 2.
- `STAGE_GAP`, 8: cycles between successive stage-start pulses; ≥ 1.
- `MAX_INFLIGHT`, 4: maximum frames admitted but not yet fully emitted; 1..15.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  scheduler accepts a beat this cycle.
- `beat_en`  out  1  beat transferred to the core this cycle (`in_valid && in_ready`).
- `beat_idx`  out  $clog2(BEATS_PER_FRAME)  index of the current beat within its frame.
- `stage_start`  out  NUM_STAGES  per-stage start pulses to the core's `in_start`.
- `core_out_start`  in  NUM_STAGES  core `out_start`; bit `NUM_STAGES-1` marks output beat 0.
- `out_valid`  out  1  output beat valid.
- `out_last`  out  1  last output beat of a frame.
- `inflight`  out  4  frames currently in flight.
- `err_underrun`  out  1  sticky: `in_valid` dropped mid-frame.
- `err_overrun`  out  1  sticky: unexpected output frame start.

## Operation
- FSM `IDLE` → `FILL` → `IDLE`.
  - `IDLE`: `in_ready = (inflight < MAX_INFLIGHT)`. On `in_valid && in_ready`, set `beat_idx = 0`, fire `stage_start[0]` the same cycle, increment `inflight`, and go to `FILL`.
  - `FILL`: `in_ready = 1`. `beat_idx` increments on every cycle, regardless of `in_valid`, because the core cannot stall.
    - If `in_valid = 0` in `FILL`, the beat still advances, `beat_en` stays 0, and `err_underrun` sets. The frame is not aborted.
    - On `beat_idx == BEATS_PER_FRAME-1`, return to `IDLE`. A new frame may start the very next cycle.
- `stage_start[k]` pulses for one cycle exactly `k*STAGE_GAP` cycles after `stage_start[0]`. Overlapping frames produce independent pulses.
- Output framing:
  - A rising pulse on `core_out_start[NUM_STAGES-1]` starts an output frame. `out_valid` is high for `BEATS_PER_FRAME` consecutive cycles, and `out_last` is high on the final one.
  - On the `out_last` cycle, `inflight` decrements.
  - If an admission and a retirement happen in the same cycle, `inflight` is unchanged.
- A pulse on `core_out_start[NUM_STAGES-1]` while an output frame is active, or while `inflight == 0`, sets `err_overrun`. The pulse is otherwise ignored.
- Error flags clear only on reset.

## Timing
- Reset values (`rst == 0`): state `IDLE`; `in_ready=0`, `beat_en=0`, `beat_idx=0`, `stage_start=0`, `out_valid=0`, `out_last=0`, `inflight=0`; both error flags 0; delay line cleared.
- `in_ready` is registered. It rises in the first cycle after reset deasserts.
- `stage_start[0]` is combinational with the accepting handshake. All other `stage_start` bits are registered taps.
- `out_valid` rises in the cycle after the `core_out_start` pulse.
- Back-to-back frames: frame starts are exactly `BEATS_PER_FRAME` cycles apart when upstream keeps `in_valid` high and credits are available.
- `inflight == MAX_INFLIGHT`: `in_ready` deasserts in `IDLE`. It reasserts the cycle after the `out_last` that frees a credit.
- Reset mid-frame: all pending stage pulses and output framing are discarded immediately. No pulse is emitted after reset.

## Configuration
- `NTT_SCHED_STATS_EN`
  - Defined: adds outputs `frames_in[31:0]` and `frames_out[31:0]`.
    - `frames_in` increments on each frame admission; `frames_out` increments on each `out_last`.
    - Both wrap modulo 2^32 and reset to 0.
  - Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package `ntt_sched_pkg`:
  - State enum `sched_state_t` (`IDLE`, `FILL`).
  - Width function for `beat_idx`.
  - Constant `INFLIGHT_W = 4`.
- Sub-module `ntt_start_delay_line`:
  - Shift register of length `(NUM_STAGES-1)*STAGE_GAP`, fed by `stage_start[0]`.
  - Tap `k*STAGE_GAP-1` drives `stage_start[k]`.
  - Synchronous active-low clear.

## Test plan
- Reset then single frame: `in_valid` high for 8 cycles from t0. Expect `stage_start[0]`@t0, `stage_start[1]`@t0+8, …, `stage_start[8]`@t0+64, `beat_idx` 0..7, and `inflight=1`.
- Continuous input with the core stubbed never emitting `out_start`: exactly 4 frames admitted, then `in_ready=0` indefinitely. One `out_start` pulse → `out_valid` for 8 cycles, then `in_ready` returns.
- `in_valid` low on beat 3 of a frame: `beat_idx` still reaches 7 on schedule, `beat_en=0` on that cycle, `err_underrun=1` sticky.
- Spurious `core_out_start[8]` with `inflight=0`: `err_overrun=1` and `out_valid` stays 0.
- Reset asserted at t0+20 of a frame: no `stage_start` bits fire afterwards, all outputs reach reset values the next cycle, and `inflight=0`.
- With `NTT_SCHED_STATS_EN` defined: after 3 frames in and 2 out, expect `frames_in=3` and `frames_out=2`.
